// File: rtl/fcs_xor_engine.sv
// fcs_xor_engine: CRC-difference engine producing the FCS correction for a
// modified frame. Two CRC registers start from INIT; one folds the payload,
// the other folds an equal-length all-zero stream. Their XOR equals the CRC of
// the payload with a zero initial value, which is XORed into the frame's FCS.
// All state updates on the falling edge of clk with synchronous active-high rst.
// Optional feature macro: FCS_XOR_LEN_CNT_EN enables the frame_bits counter.
module fcs_xor_engine #(
  parameter int unsigned      CRC_W     = 32,
  parameter logic [CRC_W-1:0] POLY      = CRC_W'(32'h04C11DB7),
  parameter logic [CRC_W-1:0] INIT      = '1,
  parameter int unsigned      DATA_W    = 1,
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              abort,
  output logic [CRC_W-1:0]  fcs_xor,
  output logic              fcs_valid,
  output logic              busy,
  output logic [15:0]       frame_bits
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [CRC_W-1:0]  data_crc, data_nx;
  logic [CRC_W-1:0]  zero_crc, zero_nx;

  // Fold DATA_W bits into a CRC, one shift-register step per bit.
  function automatic logic [CRC_W-1:0] fold(input logic [CRC_W-1:0] crc_in,
                                            input logic [DATA_W-1:0] bits);
    logic [CRC_W-1:0] c;
    logic             b;
    int               idx;
    c = crc_in;
    for (int i = 0; i < int'(DATA_W); i++) begin
      idx = MSB_FIRST ? (int'(DATA_W) - 1 - i) : i;
      b   = bits[idx];
      c   = {c[CRC_W-2:0], 1'b0} ^ (POLY & {CRC_W{b ^ c[CRC_W-1]}});
    end
    return c;
  endfunction

  // Next-state and next CRC values; a start from IDLE/DONE re-INITs before folding.
  always_comb begin
    state_nx = state;
    data_nx  = data_crc;
    zero_nx  = zero_crc;
    if (abort) begin
      state_nx = IDLE;
      data_nx  = INIT;
      zero_nx  = INIT;
    end else if (s_valid) begin
      if (state == RUN) begin
        data_nx = fold(data_crc, s_data);
        zero_nx = fold(zero_crc, DATA_W'(0));
      end else begin
        data_nx = fold(INIT, s_data);
        zero_nx = fold(INIT, DATA_W'(0));
      end
      state_nx = s_last ? DONE : RUN;
    end
  end

  // State, CRC registers and registered outputs.
  always_ff @(negedge clk) begin
    if (rst) begin
      state     <= IDLE;
      data_crc  <= INIT;
      zero_crc  <= INIT;
      fcs_xor   <= '0;
      fcs_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      data_crc  <= data_nx;
      zero_crc  <= zero_nx;
      fcs_xor   <= data_nx ^ zero_nx;
      fcs_valid <= (state_nx == DONE);
      busy      <= (state_nx == RUN);
    end
  end

`ifdef FCS_XOR_LEN_CNT_EN
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(DATA_W);

  logic [CNT_W-1:0] bits_nx;
  logic [CNT_W:0]   bits_sum;

  // Folded-bit counter: restarts on a frame start, saturates, frozen otherwise.
  always_comb begin
    bits_nx  = frame_bits;
    bits_sum = (state == RUN) ? ({1'b0, frame_bits} + STEP) : STEP;
    if (abort) begin
      bits_nx = '0;
    end else if (s_valid) begin
      bits_nx = bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
    end
  end

  // Counter register.
  always_ff @(negedge clk) begin
    if (rst) begin
      frame_bits <= '0;
    end else begin
      frame_bits <= bits_nx;
    end
  end
`else
  // Counter not built.
  assign frame_bits = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fcs_xor_engine.sv
// Directed self-checking bench for fcs_xor_engine: default 32-bit engine,
// byte-wide MSB/LSB-first engines and a 16-bit CRC-CCITT engine side by side.
module tb_fcs_xor_engine;

`ifdef FCS_XOR_LEN_CNT_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  // Default engine (CRC-32, 1 bit per beat).
  logic        a_valid, a_data, a_last, a_abort;
  logic [31:0] a_fcs;
  logic        a_fv, a_busy;
  logic [15:0] a_bits;

  // Byte-wide engines, MSB-first and LSB-first, sharing handshake.
  logic        b_valid, b_last, b_abort;
  logic [7:0]  bm_data, bl_data;
  logic [31:0] bm_fcs, bl_fcs;
  logic        bm_fv, bl_fv, bm_busy, bl_busy;
  logic [15:0] bm_bits, bl_bits;

  // 16-bit engine.
  logic        c_valid, c_data, c_last, c_abort;
  logic [15:0] c_fcs;
  logic        c_fv, c_busy;
  logic [15:0] c_bits;

  int errors = 0;
  int checks = 0;

  fcs_xor_engine dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_data(a_data), .s_last(a_last),
    .abort(a_abort), .fcs_xor(a_fcs), .fcs_valid(a_fv), .busy(a_busy),
    .frame_bits(a_bits)
  );

  fcs_xor_engine #(.DATA_W(8), .MSB_FIRST(1'b1)) dut_bm (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_data(bm_data), .s_last(b_last),
    .abort(b_abort), .fcs_xor(bm_fcs), .fcs_valid(bm_fv), .busy(bm_busy),
    .frame_bits(bm_bits)
  );

  fcs_xor_engine #(.DATA_W(8), .MSB_FIRST(1'b0)) dut_bl (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_data(bl_data), .s_last(b_last),
    .abort(b_abort), .fcs_xor(bl_fcs), .fcs_valid(bl_fv), .busy(bl_busy),
    .frame_bits(bl_bits)
  );

  fcs_xor_engine #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF)) dut_c (
    .clk(clk), .rst(rst), .s_valid(c_valid), .s_data(c_data), .s_last(c_last),
    .abort(c_abort), .fcs_xor(c_fcs), .fcs_valid(c_fv), .busy(c_busy),
    .frame_bits(c_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied 1 time unit after a falling edge and removed 1 unit
  // after the next one; outputs are read at that same point.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic a_beat(input logic d, input logic l);
    a_valid = 1'b1; a_data = d; a_last = l;
    settle();
    a_valid = 1'b0; a_last = 1'b0; a_data = 1'b0;
  endtask

  task automatic c_beat(input logic d, input logic l);
    c_valid = 1'b1; c_data = d; c_last = l;
    settle();
    c_valid = 1'b0; c_last = 1'b0; c_data = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1'($urandom); a_data = 1'($urandom); a_last = 1'($urandom);
      a_abort = 1'($urandom);
      c_valid = 1'($urandom); c_data = 1'($urandom); c_last = 1'($urandom);
      c_abort = 1'($urandom);
      b_valid = 1'($urandom); b_last = 1'($urandom); b_abort = 1'($urandom);
      bm_data = 8'($urandom); bl_data = 8'($urandom);
      settle();
    end
    rst = 1'b0;
    a_valid = 1'b0; a_data = 1'b0; a_last = 1'b0; a_abort = 1'b0;
    c_valid = 1'b0; c_data = 1'b0; c_last = 1'b0; c_abort = 1'b0;
    b_valid = 1'b0; b_last = 1'b0; b_abort = 1'b0; bm_data = '0; bl_data = '0;
    checks++;
    if (a_fcs !== 32'h0) begin errors++; $display("FAIL reset_fcs got=%h exp=0", a_fcs); end
    checks++;
    if (a_fv !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags got fv=%b busy=%b exp 0 0", a_fv, a_busy);
    end
    checks++;
    if (a_bits !== 16'h0) begin errors++; $display("FAIL reset_bits got=%0d exp=0", a_bits); end
    checks++;
    if (c_fcs !== 16'h0 || c_fv !== 1'b0 || c_busy !== 1'b0) begin
      errors++; $display("FAIL reset_c got fcs=%h fv=%b busy=%b exp 0 0 0", c_fcs, c_fv, c_busy);
    end
  endtask

  task automatic test_single_bit();
    a_beat(1'b1, 1'b1);
    checks++;
    if (a_fcs !== 32'h04C11DB7 || a_fv !== 1'b1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL single_bit got fcs=%h fv=%b busy=%b exp 04c11db7 1 0", a_fcs, a_fv, a_busy);
    end
    checks++;
    if (a_bits !== (LEN_EN ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL single_bit_len got=%0d exp=%0d", a_bits, LEN_EN ? 1 : 0);
    end
    settle();
    checks++;
    if (a_fcs !== 32'h04C11DB7 || a_fv !== 1'b1) begin
      errors++; $display("FAIL done_hold got fcs=%h fv=%b exp 04c11db7 1", a_fcs, a_fv);
    end
  endtask

  task automatic test_two_bits_and_zeros();
    a_beat(1'b1, 1'b0);
    checks++;
    if (a_fcs !== 32'h04C11DB7 || a_fv !== 1'b0 || a_busy !== 1'b1) begin
      errors++; $display("FAIL two_bits_first got fcs=%h fv=%b busy=%b exp 04c11db7 0 1", a_fcs, a_fv, a_busy);
    end
    settle();
    checks++;
    if (a_fcs !== 32'h04C11DB7 || a_busy !== 1'b1) begin
      errors++; $display("FAIL run_hold got fcs=%h busy=%b exp 04c11db7 1", a_fcs, a_busy);
    end
    a_beat(1'b0, 1'b1);
    checks++;
    if (a_fcs !== 32'h09823B6E || a_fv !== 1'b1) begin
      errors++; $display("FAIL two_bits got fcs=%h fv=%b exp 09823b6e 1", a_fcs, a_fv);
    end
    a_beat(1'b0, 1'b0);
    checks++;
    if (a_fv !== 1'b0 || a_busy !== 1'b1 || a_fcs !== 32'h0) begin
      errors++; $display("FAIL zeros_start got fv=%b busy=%b fcs=%h exp 0 1 0", a_fv, a_busy, a_fcs);
    end
    for (int i = 1; i < 64; i++) a_beat(1'b0, (i == 63));
    checks++;
    if (a_fcs !== 32'h0 || a_fv !== 1'b1) begin
      errors++; $display("FAIL zeros_end got fcs=%h fv=%b exp 0 1", a_fcs, a_fv);
    end
    checks++;
    if (a_bits !== (LEN_EN ? 16'd64 : 16'd0)) begin
      errors++; $display("FAIL zeros_len got=%0d exp=%0d", a_bits, LEN_EN ? 64 : 0);
    end
  endtask

  // "123456789" has CRC 0x89A1897F with poly 04C11DB7, zero init, no reflection.
  task automatic test_widths();
    logic [7:0] msg [9];
    logic [7:0] byte_v, rev;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    for (int k = 0; k < 9; k++) begin
      byte_v = msg[k];
      for (int j = 7; j >= 0; j--) a_beat(byte_v[j], (k == 8) && (j == 0));
    end
    checks++;
    if (a_fcs !== 32'h89A1897F || a_fv !== 1'b1) begin
      errors++; $display("FAIL serial_check got fcs=%h fv=%b exp 89a1897f 1", a_fcs, a_fv);
    end
    for (int k = 0; k < 9; k++) begin
      byte_v = msg[k];
      for (int j = 0; j < 8; j++) rev[j] = byte_v[7-j];
      b_valid = 1'b1; b_last = (k == 8); bm_data = byte_v; bl_data = rev;
      settle();
      b_valid = 1'b0; b_last = 1'b0;
    end
    checks++;
    if (bm_fcs !== 32'h89A1897F || bm_fv !== 1'b1) begin
      errors++; $display("FAIL byte_msb got fcs=%h fv=%b exp 89a1897f 1", bm_fcs, bm_fv);
    end
    checks++;
    if (bl_fcs !== 32'h89A1897F || bl_fv !== 1'b1) begin
      errors++; $display("FAIL byte_lsb got fcs=%h fv=%b exp 89a1897f 1", bl_fcs, bl_fv);
    end
    checks++;
    if (a_bits !== (LEN_EN ? 16'd72 : 16'd0) || bm_bits !== (LEN_EN ? 16'd72 : 16'd0)) begin
      errors++; $display("FAIL width_len got a=%0d b=%0d exp=%0d", a_bits, bm_bits, LEN_EN ? 72 : 0);
    end
  endtask

  task automatic test_abort();
    a_beat(1'b1, 1'b0);
    a_abort = 1'b1;
    a_beat(1'b1, 1'b1);
    a_abort = 1'b0;
    checks++;
    if (a_fv !== 1'b0 || a_busy !== 1'b0 || a_fcs !== 32'h0) begin
      errors++; $display("FAIL abort got fv=%b busy=%b fcs=%h exp 0 0 0", a_fv, a_busy, a_fcs);
    end
    checks++;
    if (a_bits !== 16'h0) begin errors++; $display("FAIL abort_len got=%0d exp=0", a_bits); end
    settle();
    checks++;
    if (a_fv !== 1'b0) begin errors++; $display("FAIL abort_stays got fv=%b exp 0", a_fv); end
    a_beat(1'b1, 1'b1);
    checks++;
    if (a_fcs !== 32'h04C11DB7 || a_fv !== 1'b1) begin
      errors++; $display("FAIL after_abort got fcs=%h fv=%b exp 04c11db7 1", a_fcs, a_fv);
    end
  endtask

  task automatic test_back_to_back();
    c_beat(1'b1, 1'b1);
    checks++;
    if (c_fcs !== 16'h1021 || c_fv !== 1'b1) begin
      errors++; $display("FAIL crc16_bit got fcs=%h fv=%b exp 1021 1", c_fcs, c_fv);
    end
    c_beat(1'b1, 1'b1);
    checks++;
    if (c_fcs !== 16'h1021 || c_fv !== 1'b1) begin
      errors++; $display("FAIL b2b_reinit got fcs=%h fv=%b exp 1021 1", c_fcs, c_fv);
    end
    c_beat(1'b0, 1'b0);
    checks++;
    if (c_fv !== 1'b0 || c_busy !== 1'b1 || c_fcs !== 16'h0) begin
      errors++; $display("FAIL b2b_start got fv=%b busy=%b fcs=%h exp 0 1 0", c_fv, c_busy, c_fcs);
    end
    c_beat(1'b1, 1'b1);
    checks++;
    if (c_fcs !== 16'h1021 || c_fv !== 1'b1 || c_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_second got fcs=%h fv=%b busy=%b exp 1021 1 0", c_fcs, c_fv, c_busy);
    end
    checks++;
    if (c_bits !== (LEN_EN ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL b2b_len got=%0d exp=%0d", c_bits, LEN_EN ? 2 : 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_data = 1'b0; a_last = 1'b0; a_abort = 1'b0;
    c_valid = 1'b0; c_data = 1'b0; c_last = 1'b0; c_abort = 1'b0;
    b_valid = 1'b0; b_last = 1'b0; b_abort = 1'b0; bm_data = '0; bl_data = '0;
    #1;
    test_reset();
    test_single_bit();
    test_two_bits_and_zeros();
    test_widths();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
